// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter, LSB first, paced by an oversampling baud tick.
// Debug ports expose the state, the tick counter and the data-bit index.
module uart_tx #(
    parameter int SAMPLE_RATE = 16,
    parameter int STOP_TICKS  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       baud_rate_clk,
    input  logic       tx_start,
    input  logic [7:0] din,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done,
    output logic [1:0] machine_state,
    output logic [4:0] tick,
    output logic [2:0] bit_num
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [4:0] BIT_LAST  = 5'(SAMPLE_RATE - 1);
    localparam logic [4:0] STOP_LAST = 5'(STOP_TICKS - 1);

    state_t     state;
    state_t     state_n;
    logic [4:0] tick_n;
    logic [2:0] bit_n;
    logic [7:0] shreg;
    logic [7:0] shreg_n;
    logic       tx_n;
    logic       done_n;

    assign tx_busy       = (state != IDLE);
    assign machine_state = state;

    // Next-state, counter and shift-register logic; tx is precomputed for the flop.
    always_comb begin
        state_n = state;
        tick_n  = tick;
        bit_n   = bit_num;
        shreg_n = shreg;
        done_n  = 1'b0;
        tx_n    = 1'b1;
        unique case (state)
            IDLE: begin
                if (tx_start) begin
                    shreg_n = din;
                    tick_n  = '0;
                    state_n = START;
                end
            end
            START: begin
                if (baud_rate_clk) begin
                    if (tick == BIT_LAST) begin
                        tick_n  = '0;
                        bit_n   = '0;
                        state_n = DATA;
                    end else begin
                        tick_n = tick + 5'd1;
                    end
                end
            end
            DATA: begin
                if (baud_rate_clk) begin
                    if (tick == BIT_LAST) begin
                        tick_n  = '0;
                        shreg_n = {1'b0, shreg[7:1]};
                        if (bit_num == 3'd7) begin
                            state_n = STOP;
                        end else begin
                            bit_n = bit_num + 3'd1;
                        end
                    end else begin
                        tick_n = tick + 5'd1;
                    end
                end
            end
            STOP: begin
                if (baud_rate_clk) begin
                    if (tick == STOP_LAST) begin
                        tick_n  = '0;
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        tick_n = tick + 5'd1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        // line level follows the state being entered so tx stays a clean flop
        unique case (state_n)
            IDLE:    tx_n = 1'b1;
            START:   tx_n = 1'b0;
            DATA:    tx_n = shreg_n[0];
            STOP:    tx_n = 1'b1;
            default: tx_n = 1'b1;
        endcase
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            tick    <= '0;
            bit_num <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
            tx_done <= 1'b0;
        end else begin
            state   <= state_n;
            tick    <= tick_n;
            bit_num <= bit_n;
            shreg   <= shreg_n;
            tx      <= tx_n;
            tx_done <= done_n;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: two transmitters (1 and 2 stop bits) against a tick-level frame model.
// Random bytes, gaps, baud jitter, busy requests, back-to-back and mid-frame reset.
module tb_uart_tx;

    localparam int SR  = 16;
    localparam int PER = 4;
    localparam int STP [2] = '{16, 32};

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic       baud     = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] din      = 8'h00;

    logic       tx_w   [2];
    logic       busy_w [2];
    logic       done_w [2];
    logic [1:0] st_w   [2];
    logic [4:0] tk_w   [2];
    logic [2:0] bn_w   [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int bcnt  = 0;
    bit fix_baud = 1'b1;

    // values seen by the DUT at the latest rising edge
    logic       s_rst   = 1'b0;
    logic       s_baud  = 1'b0;
    logic       s_start = 1'b0;
    logic [7:0] s_din   = 8'h00;

    // reference model state per instance
    bit         act   [2] = '{0, 0};
    int         t     [2] = '{0, 0};
    logic [7:0] cur   [2];
    logic [7:0] rx    [2];
    bit         fx    [2] = '{0, 0};
    int         c_acc [2] = '{0, 0};
    int         c_d0  [2] = '{0, 0};
    int         c_s0  [2] = '{0, 0};
    bit         dseen [2] = '{0, 0};

    always #5 clk = ~clk;

    uart_tx #(.SAMPLE_RATE(SR), .STOP_TICKS(16)) u0 (
        .clk           (clk),
        .reset         (reset),
        .baud_rate_clk (baud),
        .tx_start      (tx_start),
        .din           (din),
        .tx            (tx_w[0]),
        .tx_busy       (busy_w[0]),
        .tx_done       (done_w[0]),
        .machine_state (st_w[0]),
        .tick          (tk_w[0]),
        .bit_num       (bn_w[0])
    );

    uart_tx #(.SAMPLE_RATE(SR), .STOP_TICKS(32)) u1 (
        .clk           (clk),
        .reset         (reset),
        .baud_rate_clk (baud),
        .tx_start      (tx_start),
        .din           (din),
        .tx            (tx_w[1]),
        .tx_busy       (busy_w[1]),
        .tx_done       (done_w[1]),
        .machine_state (st_w[1]),
        .tick          (tk_w[1]),
        .bit_num       (bn_w[1])
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d @cyc %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic string tg(input int i, input string s);
        return $sformatf("u%0d_%s", i, s);
    endfunction

    // One clock of the frame model: a frame is 9*SR + STOP ticks long,
    // line level is a function of how many ticks have elapsed.
    task automatic step(input int i);
        int  n;
        int  k;
        int  r;
        int  d;
        bit  was;
        bit  ended;
        n = 9 * SR + STP[i];
        if (!s_rst) begin
            chk(tg(i, "rst_tx"), 32'(tx_w[i]), 1);
            chk(tg(i, "rst_busy"), 32'(busy_w[i]), 0);
            chk(tg(i, "rst_done"), 32'(done_w[i]), 0);
            chk(tg(i, "rst_state"), 32'(st_w[i]), 0);
            chk(tg(i, "rst_tick"), 32'(tk_w[i]), 0);
            chk(tg(i, "rst_bit"), 32'(bn_w[i]), 0);
            act[i] = 1'b0;
            return;
        end
        was   = act[i];
        ended = 1'b0;
        fx[i] = fx[i] & fix_baud;
        if (was && s_baud) begin
            t[i]++;
            if (t[i] == SR) c_d0[i] = cyc;
            if (t[i] == 2 * SR && fx[i])
                chk(tg(i, "bit0_len"), 32'(cyc - c_d0[i]), SR * PER);
            if (t[i] == 9 * SR) c_s0[i] = cyc;
            if (t[i] == n) begin
                ended    = 1'b1;
                act[i]   = 1'b0;
                dseen[i] = 1'b1;
                chk(tg(i, "done"), 32'(done_w[i]), 1);
                chk(tg(i, "rx_byte"), 32'(rx[i]), 32'(cur[i]));
                if (fx[i]) begin
                    chk(tg(i, "stop_len"), 32'(cyc - c_s0[i]), STP[i] * PER);
                    d = cyc - c_acc[i];
                    chk(tg(i, "frame_len"),
                        32'(d > (n - 1) * PER && d <= n * PER), 1);
                end
            end
        end
        if (!ended) chk(tg(i, "no_done"), 32'(done_w[i]), 0);
        if (!was && s_start) begin
            act[i]   = 1'b1;
            t[i]     = 0;
            cur[i]   = s_din;
            rx[i]    = 8'h00;
            fx[i]    = fix_baud;
            c_acc[i] = cyc;
        end
        if (act[i]) begin
            chk(tg(i, "busy"), 32'(busy_w[i]), 1);
            if (t[i] < SR) begin
                chk(tg(i, "st_start"), 32'(st_w[i]), 1);
                chk(tg(i, "tk_start"), 32'(tk_w[i]), 32'(t[i]));
                chk(tg(i, "tx_start"), 32'(tx_w[i]), 0);
            end else if (t[i] < 9 * SR) begin
                k = (t[i] - SR) / SR;
                r = (t[i] - SR) % SR;
                chk(tg(i, "st_data"), 32'(st_w[i]), 2);
                chk(tg(i, "tk_data"), 32'(tk_w[i]), 32'(r));
                chk(tg(i, "bit_num"), 32'(bn_w[i]), 32'(k));
                chk(tg(i, "tx_data"), 32'(tx_w[i]), 32'(cur[i][k]));
                if (r == SR / 2) rx[i][k] = tx_w[i];
            end else begin
                chk(tg(i, "st_stop"), 32'(st_w[i]), 3);
                chk(tg(i, "tk_stop"), 32'(tk_w[i]), 32'(t[i] - 9 * SR));
                chk(tg(i, "tx_stop"), 32'(tx_w[i]), 1);
            end
        end else begin
            chk(tg(i, "idle_tx"), 32'(tx_w[i]), 1);
            chk(tg(i, "idle_busy"), 32'(busy_w[i]), 0);
            chk(tg(i, "idle_st"), 32'(st_w[i]), 0);
            chk(tg(i, "idle_tk"), 32'(tk_w[i]), 0);
        end
    endtask

    always @(posedge clk) begin
        s_rst   <= reset;
        s_baud  <= baud;
        s_start <= tx_start;
        s_din   <= din;
    end

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) step(i);
        if (fix_baud) begin
            bcnt = (bcnt + 1) % PER;
            baud = (bcnt == 0);
        end else begin
            baud = ($urandom_range(0, 2) == 0);
        end
    end

    task automatic send(input logic [7:0] b);
        tx_start = 1'b1;
        din      = b;
        @(negedge clk);
        tx_start = 1'b0;
        din      = 8'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy_w[0] || busy_w[1]) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) chk("idle_timeout", 0, 1);
        @(negedge clk);
    endtask

    initial begin
        int n;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        send(8'hA5);
        repeat (200) @(negedge clk);
        tx_start = 1'b1;
        din      = 8'hFF;
        @(negedge clk);
        tx_start = 1'b0;
        wait_idle();
        repeat (40) @(negedge clk);

        dseen    = '{0, 0};
        tx_start = 1'b1;
        din      = 8'h00;
        @(negedge clk);
        din = 8'h81;
        n = 0;
        while (!(dseen[0] && dseen[1]) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 4000) chk("b2b_timeout", 0, 1);
        @(negedge clk);
        tx_start = 1'b0;
        wait_idle();

        fix_baud = 1'b0;
        for (int f = 0; f < 20; f++) begin
            wait_idle();
            repeat ($urandom_range(0, 10)) @(negedge clk);
            send(8'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(20, 300)) @(negedge clk);
                send(8'($urandom));
            end
        end
        wait_idle();

        fix_baud = 1'b1;
        send(8'h5A);
        n = 0;
        while (!(st_w[0] == 2'd2 && bn_w[0] == 3'd3) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("bit3_timeout", 0, 1);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        send(8'h3C);
        wait_idle();
        repeat (10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
